// File: rtl/sequential_capture_if.sv
// Bundle of the serial-in / parallel-out handshake signals of sequential_capture.
// The slave side is the receiver; the master side is the source plus consumer.
interface sequential_capture_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             start;
    logic             in;
    logic             abort;
    logic             clr_ovr;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;

    modport master (
        output start, in, abort, clr_ovr, ready_in,
        input  data_out, valid_out, busy, bit_cnt, overrun
    );

    modport slave (
        input  start, in, abort, clr_ovr, ready_in,
        output data_out, valid_out, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/sequential_capture.sv
// Serial-to-parallel receiver: collects WIDTH bits on start-qualified edges and
// offers each completed word on a registered valid/ready output with sticky overrun.
module sequential_capture #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 master_rst_n,
    sequential_capture_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    ostate_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             transfer;
    logic [CW-1:0]    pos;

    // State register
    always_ff @(posedge clk) begin
        if (!master_rst_n) begin
            state_q <= EMPTY;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign transfer = (state_q == FULL) && bus.ready_in;

    // Output-register occupancy
    always_comb begin
        state_d = state_q;
        if (word_done) begin
            state_d = FULL;
        end else if (transfer) begin
            state_d = EMPTY;
        end
    end

    // Bit assembly, word delivery and overrun tracking
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        ovr_d     = ovr_q;
        word      = '0;
        word_done = 1'b0;
        pos       = MSB_FIRST ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;

        if (bus.abort) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (bus.start) begin
            shift_d[pos] = bus.in;
            if (cnt_q == CW'(WIDTH - 1)) begin
                word      = shift_d;
                word_done = 1'b1;
                shift_d   = '0;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
        // A finished word is only kept if the output slot is free or being drained now
        if (word_done) begin
            if ((state_q == EMPTY) || transfer) begin
                data_d = word;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (cnt_d != '0);
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = (state_q == FULL);
    assign bus.busy      = busy_q;
    assign bus.bit_cnt   = cnt_q;
    assign bus.overrun   = ovr_q;
endmodule
